// File: rtl/fifo_drain_if.sv
// fifo_drain_if
// Groups the FIFO read-side signals and the downstream valid/ready stream
// used by the fifo_drain block.
//   fifo_dav   : FIFO not-empty flag (FIFO -> drain)
//   fifo_read  : one-cycle read pulse (drain -> FIFO)
//   fifo_data  : 9-bit FIFO word, bit 8 = end-of-packet (FIFO -> drain)
//   out_data   : head payload (drain -> consumer)
//   out_last   : head end-of-packet marker (drain -> consumer)
//   out_valid  : output buffer non-empty (drain -> consumer)
//   out_ready  : consumer accepts head word (consumer -> drain)
// Modport master is the drain's view; slave is the FIFO/consumer view.
interface fifo_drain_if;
  logic       fifo_dav;
  logic       fifo_read;
  logic [8:0] fifo_data;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  fifo_dav,
    input  fifo_data,
    input  out_ready,
    output fifo_read,
    output out_data,
    output out_last,
    output out_valid
  );

  modport slave (
    output fifo_dav,
    output fifo_data,
    output out_ready,
    input  fifo_read,
    input  out_data,
    input  out_last,
    input  out_valid
  );
endinterface

// File: rtl/fifo_drain.sv
// fifo_drain
// Read-side master for a 16-deep, 9-bit FIFO. Issues single-cycle read
// pulses while data is available, captures each returned word one cycle
// later and presents it through a 2-entry valid/ready output buffer.
// Bit 8 of each FIFO word travels with the payload as out_last.
// Ports:
//   clk, reset_b : clock, asynchronous active-low reset
//   enable       : permits new FIFO reads
//   bus          : fifo_drain_if.master (FIFO read side + output stream)
//   busy         : FSM is in READ or CAPTURE
//   word_count   : words captured from the FIFO (wraps)
//   pkt_count    : end-of-packet words accepted downstream (wraps)
module fifo_drain #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             enable,
  fifo_drain_if.master     bus,
  output logic             busy,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0][7:0]  buf_data_q, buf_data_d;
  logic [1:0]       buf_last_q, buf_last_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             fifo_read_q, fifo_read_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             cap_s;
  logic             pop_s;

  // Next-state logic. CAPTURE always returns to IDLE so fifo_dav is only
  // re-sampled after the FIFO read pointer has moved past the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && bus.fifo_dav && (cnt_q < 2'd2)) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output buffer, counters and registered output values.
  always_comb begin
    cap_s       = (state_q == CAPTURE);
    pop_s       = out_valid_q & bus.out_ready;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    head_d      = head_q;
    tail_d      = tail_q;
    word_cnt_d  = word_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    cnt_d       = cnt_q;

    // fifo_data is only looked at here: outside CAPTURE its payload may float.
    if (cap_s) begin
      buf_data_d[tail_q] = bus.fifo_data[7:0];
      buf_last_d[tail_q] = bus.fifo_data[8];
      tail_d             = ~tail_q;
      word_cnt_d         = word_cnt_q + CNT_W'(1);
    end else begin
      tail_d     = tail_q;
      word_cnt_d = word_cnt_q;
    end

    if (pop_s) begin
      head_d = ~head_q;
      if (buf_last_q[head_q]) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end else begin
        pkt_cnt_d = pkt_cnt_q;
      end
    end else begin
      head_d    = head_q;
      pkt_cnt_d = pkt_cnt_q;
    end

    // A simultaneous capture and pop leaves the occupancy unchanged.
    case ({cap_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Outputs are registered from next-state values so they line up with the
    // state they describe without extra latency.
    fifo_read_d = (state_d == READ);
    busy_d      = (state_d != IDLE);
    out_valid_d = (cnt_d != 2'd0);
    out_data_d  = buf_data_d[head_d];
    out_last_d  = buf_last_d[head_d];
  end

  // State and datapath registers; reset drops any in-flight word.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      buf_data_q  <= {2{8'h00}};
      buf_last_q  <= 2'b00;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      cnt_q       <= 2'd0;
      word_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.fifo_read = fifo_read_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign word_count    = word_cnt_q;
  assign pkt_count     = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain
// Self-checking bench for fifo_drain: a behavioural FIFO, a stream
// scoreboard, a cycle table, directed corner sequences and random traffic.
module tb_fifo_drain;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        enable;
  logic        enable4;
  logic        busy, busy4;
  logic [15:0] wc, pc;
  logic [3:0]  wc4, pc4;

  always #5 clk = ~clk;

  fifo_drain_if bus();
  fifo_drain_if bus4();

  fifo_drain dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .bus(bus),
    .busy(busy), .word_count(wc), .pkt_count(pc)
  );

  fifo_drain #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_b(reset_b), .enable(enable4), .bus(bus4),
    .busy(busy4), .word_count(wc4), .pkt_count(pc4)
  );

  // ---------------- behavioural FIFO for the main DUT ----------------
  logic [8:0] fmem [0:15];
  int         n_pushed = 0;
  int         n_popped = 0;
  logic       rd_v = 1'b0;
  logic [8:0] rd_w = 9'h000;

  assign bus.fifo_dav  = (n_pushed != n_popped);
  // Junk on the data lines whenever the read data is not valid.
  assign bus.fifo_data = rd_v ? rd_w : 9'h15A;

  always @(posedge clk) begin
    rd_v <= 1'b0;
    if (bus.fifo_read && (n_pushed != n_popped)) begin
      rd_w     <= fmem[4'(n_popped)];
      rd_v     <= 1'b1;
      n_popped <= n_popped + 1;
    end
  end

  // ---------------- minimal FIFO for the CNT_W=4 DUT ----------------
  int   n4_req = 0;
  int   n4_done = 0;
  logic rd4_v = 1'b0;

  assign bus4.fifo_dav  = (n4_done != n4_req);
  assign bus4.fifo_data = rd4_v ? 9'h1C3 : 9'h03C;
  assign bus4.out_ready = 1'b1;

  always @(posedge clk) begin
    rd4_v <= 1'b0;
    if (bus4.fifo_read && (n4_done != n4_req)) begin
      rd4_v   <= 1'b1;
      n4_done <= n4_done + 1;
    end
  end

  // ---------------- scoreboard / bookkeeping ----------------
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] exp_mem [0:1023];
  int         exp_wr = 0;
  int         exp_rd = 0;
  int         drop_cnt = 0;
  int         wc_exp = 0;
  int         pc_exp = 0;
  int         cyc = 0;
  int         reads = 0;
  int         last_rd = -1;
  bit         burst_chk = 1'b0;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_word = 9'h000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [8:0] w);
    fmem[4'(n_pushed)] = w;
    n_pushed = n_pushed + 1;
    exp_mem[10'(exp_wr)] = w;
    exp_wr = exp_wr + 1;
    wc_exp = wc_exp + 1;
    if (w[8]) pc_exp = pc_exp + 1;
  endtask

  task automatic wait_idle(input int limit, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((n_pushed == n_popped) && !busy && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_word_count"}, 32'(wc), 32'(wc_exp & 32'hFFFF));
    chk({name, "_pkt_count"},  32'(pc), 32'(pc_exp & 32'hFFFF));
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Protocol monitor and in-order stream scoreboard, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!reset_b) begin
      prev_hold = 1'b0;
      last_rd   = -1;
    end else begin
      if (bus.fifo_read) begin
        reads = reads + 1;
        chk("read_while_empty", 32'(n_pushed != n_popped), 32'd1);
        if (burst_chk && (last_rd >= 0)) chk("burst_spacing", 32'(cyc - last_rd), 32'd3);
        last_rd = cyc;
      end
      if (!burst_chk) last_rd = -1;
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'({bus.out_last, bus.out_data}), 32'(prev_word));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_order", 32'({bus.out_last, bus.out_data}), 32'(exp_mem[10'(exp_rd + drop_cnt)]));
        exp_rd = exp_rd + 1;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_word = {bus.out_last, bus.out_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         push;
    logic [8:0] word;
    bit         ready;
    bit         exp_read;
    bit         exp_busy;
    bit         exp_valid;
    logic [8:0] exp_head;
  } vec_t;

  vec_t vt[$];

  initial begin
    int  r0, e0, n;
    bit  got;

    // Single word 0x1A5 with ready=1, then 4 words under backpressure.
    //             push  word    rdy   rd    busy  vld   head
    vt.push_back('{1'b1, 9'h1A5, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1A5});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{1'b1, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{1'b1, 9'h022, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b1, 9'h033, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b1, 9'h144, 1'b0, 1'b0, 1'b0, 1'b1, 9'h011});
    vt.push_back('{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1, 9'h011});
    vt.push_back('{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h011});
    vt.push_back('{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 9'h011});
    vt.push_back('{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 9'h011});
    vt.push_back('{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 9'h011});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 9'h011});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 9'h022});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 9'h033});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 9'h144});
    vt.push_back('{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000});

    reset_b       = 1'b0;
    enable        = 1'b1;
    enable4       = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_word_count", 32'(wc), 32'd0);
    chk("rst_pkt_count",  32'(pc), 32'd0);

    // Cycle table
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      bus.out_ready = vt[i].ready;
      if (vt[i].push) push(vt[i].word);
      @(negedge clk);
      chk($sformatf("tbl%0d_read", i),  32'(bus.fifo_read), 32'(vt[i].exp_read));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),          32'(vt[i].exp_busy));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid)
        chk($sformatf("tbl%0d_head", i), 32'({bus.out_last, bus.out_data}), 32'(vt[i].exp_head));
    end
    chk_counters("table");

    // Burst of 16: reads exactly 3 cycles apart, none once the FIFO is empty
    @(posedge clk);
    #1;
    burst_chk = 1'b1;
    r0 = reads;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push({(i == 15), 8'(i)});
    wait_idle(200, "burst_drain");
    burst_chk = 1'b0;
    chk("burst_reads", 32'(reads - r0), 32'd16);
    repeat (6) @(negedge clk);
    chk("burst_no_extra_read", 32'(reads - r0), 32'd16);
    chk_counters("burst");

    // Enable dropped during READ: word still delivered, no further reads
    @(posedge clk);
    #1;
    r0 = reads;
    e0 = exp_rd;
    push(9'h0A1);
    push(9'h0A2);
    push(9'h1A3);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fifo_read) begin
        enable = 1'b0;
        got = 1'b1;
        break;
      end
    end
    chk("en_first_read_seen", 32'(got), 32'd1);
    repeat (12) @(negedge clk);
    chk("en_reads_while_off", 32'(reads - r0), 32'd1);
    chk("en_word_delivered",  32'(exp_rd - e0), 32'd1);
    chk("en_idle_while_off",  32'(busy), 32'd0);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_idle(100, "en_resume_drain");
    chk("en_total_reads", 32'(reads - r0), 32'd3);
    chk_counters("enable");

    // Reset asserted during CAPTURE
    @(posedge clk);
    #1 push(9'h1B7);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fifo_read) begin
        got = 1'b1;
        break;
      end
    end
    chk("rstmid_read_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("rstmid_in_capture", 32'(busy), 32'd1);
    reset_b  = 1'b0;
    drop_cnt = drop_cnt + 1;
    wc_exp   = 0;
    pc_exp   = 0;
    #1;
    chk("rstmid_fifo_read", 32'(bus.fifo_read), 32'd0);
    chk("rstmid_busy",      32'(busy),          32'd0);
    chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid_out_data",  32'(bus.out_data),  32'd0);
    chk("rstmid_out_last",  32'(bus.out_last),  32'd0);
    chk("rstmid_word_count", 32'(wc), 32'd0);
    chk("rstmid_pkt_count",  32'(pc), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk("rstrel_busy",  32'(busy), 32'd0);
    chk("rstrel_valid", 32'(bus.out_valid), 32'd0);
    chk_counters("rstrel");
    @(posedge clk);
    #1 push(9'h1C8);
    wait_idle(50, "rstrel_drain");
    chk_counters("rstrel_after");

    // Counter wrap on the CNT_W=4 instance
    @(posedge clk);
    #1 n4_req = 17;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((n4_done == n4_req) && !busy4 && !bus4.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("wrap_drain", 32'(got), 32'd1);
    chk("wrap_word_count", 32'(wc4), 32'd1);
    chk("wrap_pkt_count",  32'(pc4), 32'd1);

    // Random traffic with random ready/enable against the scoreboard
    for (int r = 0; r < 6; r++) begin
      @(posedge clk);
      #1;
      n = $urandom_range(16, 1);
      for (int k = 0; k < n; k++) push(9'($urandom));
      for (int c = 0; c < 400; c++) begin
        @(posedge clk);
        #1;
        bus.out_ready = (($urandom % 4) != 0);
        enable        = (($urandom % 8) != 0);
        if ((n_pushed == n_popped) && !busy && !bus.out_valid) break;
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      wait_idle(100, $sformatf("rand%0d_drain", r));
      chk_counters($sformatf("rand%0d", r));
    end
    chk("all_words_delivered", 32'(exp_rd + drop_cnt), 32'(exp_wr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side master for the 16-deep, 9-bit FIFO. It watches the FIFO's data-available flag, issues single-cycle read pulses, and captures each returned word. Captured words go into a 2-entry output buffer that presents a valid/ready stream to the downstream consumer. Bit 8 of each FIFO word is carried through as an end-of-packet marker. The block also keeps word and packet statistics.

## Interface
Parameters:
- CNT_W, default 16: width of the word and packet counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- enable  in  1  allows new FIFO reads when 1.
- fifo_dav  in  1  FIFO not-empty flag.
- fifo_read  out  1  read request to the FIFO, one-cycle pulse.
- fifo_data  in  9  FIFO read data. Bits [7:0] are valid only in the cycle after fifo_read; bit 8 is the end-of-packet marker.
- out_data  out  8  payload at the head of the output buffer.
- out_last  out  1  end-of-packet marker of the head word.
- out_valid  out  1  output buffer is non-empty.
- out_ready  in  1  consumer accepts the head word when 1.
- busy  out  1  FSM is not in IDLE.
- word_count  out  CNT_W  words captured from the FIFO; wraps modulo 2^CNT_W.
- pkt_count  out  CNT_W  words with out_last=1 accepted downstream; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, READ, CAPTURE.
  - IDLE: if enable & fifo_dav & (buf_count < 2), go to READ; otherwise stay in IDLE.
  - READ: fifo_read=1 for exactly this cycle; always go to CAPTURE.
  - CAPTURE: register fifo_data[8:0] into the buffer tail, increment buf_count and word_count, then always go to IDLE.
- CAPTURE always returns to IDLE, never straight to READ. fifo_dav is not re-sampled until the FIFO read pointer has advanced; this prevents over-reading the last word.
- fifo_read is asserted only in READ, and at most one read is in flight at any time.
- Output buffer is 2 entries, FIFO-ordered, with separate head and tail indices.
  - out_valid = (buf_count != 0).
  - A pop occurs when out_valid & out_ready; it advances the head and decrements buf_count.
  - A capture and a pop in the same cycle leave buf_count unchanged and both indices advance.
  - If buf_count=2 and the FSM is in IDLE, no read is issued until a pop occurs.
- fifo_data[7:0] is never sampled outside CAPTURE, because those bits may be high-impedance.
- pkt_count increments on a pop with out_last=1.
- If enable is deasserted while in READ or CAPTURE, the in-flight word still completes and is buffered. Deasserting enable never discards data.
- Counters wrap silently: all ones + 1 = 0.

## Timing
- Reset values: fifo_read=0, out_valid=0, out_data=0, out_last=0, busy=0, word_count=0, pkt_count=0, buf_count=0, state=IDLE.
- Reset asserted mid-operation clears all state immediately, including any in-flight word; that word is lost.
- Sequence from IDLE with fifo_dav=1 sampled at edge N:
  - fifo_read high in cycle N+1.
  - Data captured at the end of cycle N+2.
  - out_valid high in cycle N+3.
- Latency from fifo_dav=1 sampled in IDLE to out_valid: 3 cycles.
- Peak throughput: 1 word per 3 cycles.
- busy is high in READ and CAPTURE.
- out_data and out_last are registered and stable while out_valid=1 & out_ready=0.
- A pop is visible on the next edge: out_valid drops, or the second entry is presented.
- fifo_dav falling while in READ has no effect; the read already issued completes.

## Test plan
- **Single word:** FIFO holds 0x1A5 (last=1, data=0xA5), out_ready=1.
  - fifo_read pulses once.
  - out_data=0xA5 and out_last=1 three cycles after dav is sampled.
  - word_count=1, pkt_count=1, FIFO ends empty.
- **Burst of 16 (full FIFO):** write 0x000..0x00F, with bit 8 set on the last word, out_ready=1.
  - 16 read pulses spaced exactly 3 cycles apart.
  - Words appear in order.
  - word_count=16, pkt_count=1, and no read is issued after fifo_dav falls.
- **Backpressure:** FIFO holds 4 words, out_ready=0.
  - Exactly 2 reads, then the FSM idles with buf_count=2 and out_data stable.
  - Raising out_ready drains all 4 words in order.
- **Enable gating:** drop enable in the READ cycle.
  - The word is still captured and presented.
  - No further fifo_read while enable=0; reads resume on re-enable.
- **Reset mid-operation:** assert reset_b=0 during CAPTURE.
  - All outputs are at reset values in the same cycle.
  - After release, the FSM is in IDLE with counters at 0.
- **Counter wrap:** with CNT_W=4, drain 17 words each with bit 8 set.
  - word_count=1 and pkt_count=1 after the 17th word.
